// File: rtl/pca_i2c_pkg.sv
// Shared constants and debug encodings for the I2C front-end blocks.
package pca_i2c_pkg;

    localparam int SYNC_STAGES_DEF    = 2;
    localparam int FILTER_CYCLES_DEF  = 4;
    localparam int TIMEOUT_CYCLES_DEF = 0;

    // Bus-level event classification, for monitors and debug views only.
    typedef enum logic [1:0] {
        EV_NONE,
        EV_START,
        EV_STOP,
        EV_TIMEOUT
    } bus_event_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Per-line synchroniser plus spike filter. level_d_o is the next filtered
// level so the parent can register edge strobes aligned with level_o.
module i2c_line_filter
    import pca_i2c_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int FILTER_CYCLES = FILTER_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic level_o,
    output logic level_d_o
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Metastability chain; resets to the idle (high) bus level.
    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end

    // Accept a new level only after FILTER_CYCLES consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (synced != filt_q) begin
            if (cnt_q == CW'(FILTER_CYCLES - 1)) filt_d = synced;
            else                                 cnt_d  = cnt_q + 1'b1;
        end
    end

    // Filtered level and run-length counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign level_o   = filt_q;
    assign level_d_o = filt_d;

endmodule

// File: rtl/i2c_bus_conditioner.sv
// Clean SCL/SDA levels, edge/START/STOP strobes, bus-busy and SCL-low timeout.
module i2c_bus_conditioner
    import pca_i2c_pkg::*;
#(
    parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int FILTER_CYCLES  = FILTER_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_o,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic bus_busy_o,
    output logic timeout_o
);

    logic scl_q, scl_d, sda_q, sda_d;
    logic rise_q, fall_q, start_q, stop_q, busy_q, busy_d;
    logic timeout_w;
    logic scl_stable_hi;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_scl (
        .clk_i(clk_i), .rst_i(rst_i), .pin_i(scl_i), .level_o(scl_q), .level_d_o(scl_d)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_sda (
        .clk_i(clk_i), .rst_i(rst_i), .pin_i(sda_i), .level_o(sda_q), .level_d_o(sda_d)
    );

    // SDA transitions only count as START/STOP when SCL is high and not moving.
    assign scl_stable_hi = scl_q & scl_d;

    // Start wins over stop/timeout so a repeated START keeps the bus busy.
    assign busy_d = start_q ? 1'b1 : ((stop_q | timeout_w) ? 1'b0 : busy_q);

    // Registered strobes, aligned with the first cycle of the new filtered level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rise_q  <= ~scl_q & scl_d;
            fall_q  <= scl_q & ~scl_d;
            start_q <= scl_stable_hi & sda_q & ~sda_d;
            stop_q  <= scl_stable_hi & ~sda_q & sda_d;
            busy_q  <= busy_d;
        end
    end

    if (TIMEOUT_CYCLES > 0) begin : g_timeout
        localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

        logic [TW-1:0] tcnt_q, tcnt_d;
        logic          to_q, to_d;

        // Count busy SCL-low cycles; fire once on reaching the limit, never wrap.
        always_comb begin
            tcnt_d = '0;
            to_d   = 1'b0;
            if (busy_q && !scl_q) begin
                if (tcnt_q >= TW'(TIMEOUT_CYCLES - 1)) to_d   = 1'b1;
                else                                   tcnt_d = tcnt_q + 1'b1;
            end
        end

        // Timeout counter and strobe register.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                tcnt_q <= '0;
                to_q   <= 1'b0;
            end else begin
                tcnt_q <= tcnt_d;
                to_q   <= to_d;
            end
        end

        assign timeout_w = to_q;
    end else begin : g_no_timeout
        assign timeout_w = 1'b0;
    end

    assign scl_o      = scl_q;
    assign sda_o      = sda_q;
    assign scl_rise_o = rise_q;
    assign scl_fall_o = fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign bus_busy_o = busy_q;
    assign timeout_o  = timeout_w;

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Self-checking bench: directed bus scenarios plus random pin activity,
// compared every cycle against a sample-history reference model.
module tb_i2c_bus_conditioner;
    import pca_i2c_pkg::*;

    localparam int S = 2;
    localparam int F = 4;
    localparam int T = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_pin = 1'b0;
    logic sda_pin = 1'b0;
    logic scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, bus_busy_o, timeout_o;

    i2c_bus_conditioner #(.SYNC_STAGES(S), .FILTER_CYCLES(F), .TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_i(rst), .scl_i(scl_pin), .sda_i(sda_pin),
        .scl_o(scl_o), .sda_o(sda_o), .scl_rise_o(scl_rise_o), .scl_fall_o(scl_fall_o),
        .start_o(start_o), .stop_o(stop_o), .bus_busy_o(bus_busy_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: pin-sample history, filtered levels, bus-level state.
    logic hs[$];
    logic hd[$];
    logic m_scl, m_sda, m_rise, m_fall, m_start, m_stop, m_busy, m_to;
    int   m_tcnt;

    // Event counters taken from DUT outputs, checked against fixed expectations.
    int c_start, c_stop, c_rise, c_fall, c_to;

    function automatic logic settle(input logic q[$], input logic cur);
        // Level flips only when the F most recent synchronised samples all disagree.
        for (int k = 0; k < F; k++)
            if (q[k] == cur) return cur;
        return ~cur;
    endfunction

    task automatic model_edge(input logic r, input logic ps, input logic pd);
        logic nscl, nsda, nbusy, nto;
        if (r) begin
            hs = {}; hd = {};
            for (int k = 0; k < S + F; k++) begin hs.push_back(1'b1); hd.push_back(1'b1); end
            m_scl = 1; m_sda = 1; m_rise = 0; m_fall = 0; m_start = 0; m_stop = 0;
            m_busy = 0; m_to = 0; m_tcnt = 0;
            return;
        end
        hs.push_back(ps); void'(hs.pop_front());
        hd.push_back(pd); void'(hd.pop_front());
        nscl  = settle(hs, m_scl);
        nsda  = settle(hd, m_sda);
        nbusy = m_start ? 1'b1 : ((m_stop || m_to) ? 1'b0 : m_busy);
        nto   = 1'b0;
        if (m_busy && !m_scl) begin
            m_tcnt++;
            if (m_tcnt == T) begin nto = 1'b1; m_tcnt = 0; end
        end else begin
            m_tcnt = 0;
        end
        m_rise  = !m_scl && nscl;
        m_fall  = m_scl && !nscl;
        m_start = m_scl && nscl && m_sda && !nsda;
        m_stop  = m_scl && nscl && !m_sda && nsda;
        m_busy  = nbusy;
        m_to    = nto;
        m_scl   = nscl;
        m_sda   = nsda;
    endtask

    task automatic step(input logic ps, input logic pd, input logic r = 1'b0);
        bus_event_t ev;
        scl_pin = ps; sda_pin = pd; rst = r;
        @(posedge clk);
        model_edge(r, ps, pd);
        @(negedge clk);
        chk("cycle", {24'd0, scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, bus_busy_o, timeout_o},
            {24'd0, m_scl, m_sda, m_rise, m_fall, m_start, m_stop, m_busy, m_to});
        ev = start_o ? EV_START : stop_o ? EV_STOP : timeout_o ? EV_TIMEOUT : EV_NONE;
        case (ev)
            EV_START:   c_start++;
            EV_STOP:    c_stop++;
            EV_TIMEOUT: c_to++;
            default: ;
        endcase
        if (scl_rise_o) c_rise++;
        if (scl_fall_o) c_fall++;
    endtask

    task automatic hold(input logic ps, input logic pd, input int n);
        repeat (n) step(ps, pd);
    endtask

    task automatic clr();
        c_start = 0; c_stop = 0; c_rise = 0; c_fall = 0; c_to = 0;
    endtask

    initial begin
        int lat;
        logic [8:0] frame;
        clr();

        // Reset held with pins low: idle-high outputs, no strobes.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
        chk("rst_scl", scl_o, 1'b1);
        chk("rst_sda", sda_o, 1'b1);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b0);
            if (scl_fall_o && lat == 0) lat = i;
        end
        chk("rst_latency", lat, 6);
        chk("rst_fall_cnt", c_fall, 1);
        chk("rst_no_start", c_start, 0);
        hold(1, 0, 10);
        hold(1, 1, 10);

        // Glitch rejection on SDA with SCL high.
        clr();
        for (int w = 1; w <= 3; w++) begin
            hold(1, 0, w);
            hold(1, 1, 10);
        end
        chk("glitch_start", c_start, 0);
        chk("glitch_stop", c_stop, 0);
        hold(1, 0, 4);
        hold(1, 1, 12);
        chk("pulse4_start", c_start, 1);
        chk("pulse4_stop", c_stop, 1);

        // Full byte frame 0xA5 + ACK.
        clr();
        frame = {8'hA5, 1'b0};
        hold(1, 1, 10);
        hold(1, 0, 20);
        for (int b = 8; b >= 0; b--) begin
            hold(0, frame[b], 20);
            hold(1, frame[b], 20);
        end
        chk("frame_busy_mid", bus_busy_o, 1'b1);
        hold(1, 1, 20);
        chk("frame_start", c_start, 1);
        chk("frame_rise", c_rise, 9);
        chk("frame_fall", c_fall, 9);
        chk("frame_stop", c_stop, 1);
        chk("frame_busy_end", bus_busy_o, 1'b0);

        // Repeated START mid-frame.
        clr();
        hold(1, 0, 20);
        hold(0, 0, 20);
        hold(0, 1, 20);
        hold(1, 1, 20);
        hold(1, 0, 20);
        chk("rs_start", c_start, 2);
        chk("rs_stop", c_stop, 0);
        chk("rs_busy", bus_busy_o, 1'b1);
        hold(0, 0, 20);
        hold(1, 0, 20);
        hold(1, 1, 20);

        // SCL and SDA changing on the same edge: edge strobe only.
        clr();
        hold(1, 0, 20);
        hold(0, 1, 20);
        hold(1, 0, 20);
        chk("simul_start", c_start, 1);
        chk("simul_stop", c_stop, 0);
        chk("simul_fall", c_fall, 1);
        chk("simul_rise", c_rise, 1);
        hold(1, 1, 20);

        // Timeout after a long SCL-low while busy.
        clr();
        hold(1, 0, 20);
        hold(0, 0, 100);
        chk("to_fire", c_to, 1);
        chk("to_busy", bus_busy_o, 1'b0);
        hold(1, 0, 10);
        hold(1, 1, 10);

        // One cycle short of the limit: no timeout.
        clr();
        hold(1, 0, 20);
        hold(0, 0, T - 1);
        hold(1, 0, 20);
        chk("to63_none", c_to, 0);
        chk("to63_busy", bus_busy_o, 1'b1);
        hold(1, 1, 20);

        // Random pin activity with occasional resets and long SCL-low holds.
        for (int seg = 0; seg < 400; seg++) begin
            logic rs, rd;
            int   dur;
            rs  = 1'($urandom);
            rd  = 1'($urandom);
            dur = ($urandom_range(0, 9) == 0) ? int'($urandom_range(40, 90)) : int'($urandom_range(1, 8));
            if ($urandom_range(0, 49) == 0) begin
                repeat ($urandom_range(1, 3)) step(rs, rd, 1'b1);
            end
            hold(rs, rd, dur);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
